uart_receiver: RTL and testbench
================================

// Module: uart_receiver
// PURPOSE
//  Serial-to-parallel UART receive stage: 8N1 frames in, 8-bit bytes out on a valid/ready handshake.
//  Sits between the serial_in pad and the 32-deep receive FIFO inside the MMIO block.
//  data_out_ready is driven by !fifo_full; data_out_valid drives fifo wr_en.
//  Reports framing, overrun and (optionally) parity errors as single-cycle pulses.
// PARAMETERS
//  CLOCK_FREQ  50_000_000  core clock frequency in Hz
//  BAUD_RATE   115200      line rate in bit/s
//                          derived: BIT_T = CLOCK_FREQ/BAUD_RATE (integer, 434); HALF_T = BIT_T/2 (217)
// PORTS
//  clk             in   1  core clock; all logic on its rising edge
//  reset           in   1  asynchronous, active-high reset
//  serial_in       in   1  asynchronous RX line; idles high
//  data_out        out  8  received byte, LSB = first data bit on the line
//  data_out_valid  out  1  data_out holds an unconsumed byte
//  data_out_ready  in   1  consumer accepts data_out on (valid && ready) at a clk edge
//  frame_error     out  1  1-cycle pulse: stop bit sampled as 0
//  overrun         out  1  1-cycle pulse: new byte arrived while previous byte still unconsumed
//  parity_error    out  1  1-cycle pulse: parity mismatch (constant 0 when parity is compiled out)
// BEHAVIOUR
//  - Reset (async): state=IDLE, counters=0, sync regs=1'b1, data_out=8'h00, all outputs 0.
//  - serial_in passes through a 2-FF synchroniser (rx_s); all decisions use rx_s only.
//  - One bit counter cnt, width $clog2(BIT_T); one 3-bit data index.
//  - FSM:
//    IDLE   rx_s==0 -> START, cnt=0.
//    START  when cnt==HALF_T-1, sample rx_s: 1 -> IDLE (glitch rejected, no flags); 0 -> DATA, cnt=0, idx=0.
//    DATA   when cnt==BIT_T-1, shift rx_s into shift[idx] and cnt=0.
//           idx==7 -> PARITY (macro defined) or STOP.
//    PARITY when cnt==BIT_T-1, latch parity bit -> STOP.
//    STOP   when cnt==BIT_T-1, sample rx_s:
//           1 -> deliver byte, go to IDLE.
//           0 -> frame_error=1 for one cycle, byte discarded, go to BREAK.
//    BREAK  stay until rx_s==1 -> IDLE (a held-low line raises exactly one frame_error).
//  - Latency: the stop-bit sample falls HALF_T + 9*BIT_T cycles after rx_s first reads 0
//    (+BIT_T with parity). data_out/data_out_valid update on the edge that samples the stop bit.
//  - Delivery rules (evaluated at the stop-sample edge):
//    valid==0, or valid&&ready same edge -> data_out<=shift, valid<=1, no overrun.
//    valid==1 && ready==0 -> overrun=1 for one cycle; data_out unchanged, new byte dropped.
//  - Handshake: valid stays high, data_out stable, until valid&&ready; then valid<=0 on that edge
//    unless a new byte is delivered on the same edge.
//  - Reset mid-frame aborts the frame; no flags; the next full frame after reset release is received normally.
// CONFIGURATION
//  UART_RX_PARITY_EN defined:
//    frame = start, 8 data, even parity, stop; PARITY state included.
//    XOR(data,parity)!=0 -> parity_error pulse at the stop-sample edge, byte discarded (no valid, no overrun).
//    Framing is still checked; a bad stop bit raises frame_error only.
//  UART_RX_PARITY_EN undefined:
//    8N1, no PARITY state, parity_error tied 0.
// TESTING (CLOCK_FREQ=50e6, BAUD_RATE=115200, BIT_T=434)
//  1 Frame 0xA5, ready=0 -> data_out=8'hA5, valid=1 held 2000 cycles; ready=1 one cycle -> valid=0 next edge.
//  2 serial_in low for 100 cycles then high -> no valid, no flags, FSM back in IDLE.
//  3 Frame 0x3C with stop bit=0, line then held low 5*BIT_T -> exactly one frame_error pulse, no valid;
//    next good frame 0x5A is received.
//  4 Frames 0x11 then 0x22 back-to-back, ready=0 -> one overrun pulse, data_out stays 8'h11;
//    repeat with ready pulsed at 0x22's stop edge -> data_out=8'h22, no overrun.
//  5 Assert reset at bit 4 of frame 0xFF -> all outputs 0 immediately;
//    after release, frame 0x81 -> data_out=8'h81.
//  6 (UART_RX_PARITY_EN) 0x07 with parity=1 -> data_out=8'h07;
//    with parity=0 -> parity_error pulse, valid stays 0.

Source files
------------

// File: rtl/uart_receiver_if.sv
// Byte-stream handshake between the UART receiver and its consumer.
// The receiver drives data/valid as master; the consumer drives ready.
interface uart_receiver_if;
  logic [7:0] data_out;
  logic       data_out_valid;
  logic       data_out_ready;

  modport master (
    output data_out,
    output data_out_valid,
    input  data_out_ready
  );

  modport slave (
    input  data_out,
    input  data_out_valid,
    output data_out_ready
  );
endinterface

// File: rtl/uart_receiver.sv
// UART receive stage: 8N1 serial in, bytes out on valid/ready.
// Even parity is compiled in when UART_RX_PARITY_EN is defined.
module uart_receiver #(
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int BAUD_RATE  = 115200
) (
  input  logic clk,
  input  logic reset,
  input  logic serial_in,
  uart_receiver_if.master rx_if,
  output logic frame_error,
  output logic overrun,
  output logic parity_error
);

  localparam int BIT_T  = CLOCK_FREQ / BAUD_RATE;
  localparam int HALF_T = BIT_T / 2;
  localparam int CW     = $clog2(BIT_T);

  localparam logic [CW-1:0] BIT_END  = CW'(BIT_T - 1);
  localparam logic [CW-1:0] HALF_END = CW'(HALF_T - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP, BRK
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE, START, DATA, STOP, BRK
  } state_t;
`endif

  state_t state_q, state_d;

  logic          rx_m, rx_s;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          fe_q, fe_d;
  logic          ov_q, ov_d;
  logic          pe_d;
  logic          deliver;
  logic          tick, half;

  assign tick = (cnt_q == BIT_END);
  assign half = (cnt_q == HALF_END);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= serial_in;
      rx_s <= rx_m;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic par_q, par_d, pe_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      par_q <= 1'b0;
      pe_q  <= 1'b0;
    end else begin
      par_q <= par_d;
      pe_q  <= pe_d;
    end
  end

  assign parity_error = pe_q;
`else
  assign parity_error = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      fe_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      fe_q    <= fe_d;
      ov_q    <= ov_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = valid_q;
    fe_d    = 1'b0;
    ov_d    = 1'b0;
    pe_d    = 1'b0;
    deliver = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
`endif

    if (valid_q && rx_if.data_out_ready)
      valid_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s)
          state_d = START;
      end
      START: begin
        if (half) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (tick) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_s;
          idx_d          = idx_q + 3'd1;
          if (idx_q == 3'd7)
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (tick) begin
          cnt_d   = '0;
          par_d   = rx_s;
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (tick) begin
          cnt_d = '0;
          if (rx_s) begin
            state_d = IDLE;
`ifdef UART_RX_PARITY_EN
            if (^{shift_q, par_q})
              pe_d = 1'b1;
            else
              deliver = 1'b1;
`else
            deliver = 1'b1;
`endif
          end else begin
            fe_d    = 1'b1;
            state_d = BRK;
          end
        end
      end
      BRK: begin
        cnt_d = '0;
        if (rx_s)
          state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase

    // A same-edge consume frees the slot for the new byte.
    if (deliver) begin
      if (!valid_q || rx_if.data_out_ready) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        ov_d = 1'b1;
      end
    end
  end

  assign rx_if.data_out       = data_q;
  assign rx_if.data_out_valid = valid_q;
  assign frame_error          = fe_q;
  assign overrun              = ov_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Directed plus random frames for uart_receiver; bytes and flag
// pulses are compared against an expected-byte queue and counts.
module tb_uart_receiver;

  localparam int BIT_T = 50_000_000 / 115200;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic serial_in = 1'b1;
  logic frame_error, overrun, parity_error;

  uart_receiver_if rx_if();

  uart_receiver dut (
    .clk(clk),
    .reset(reset),
    .serial_in(serial_in),
    .rx_if(rx_if),
    .frame_error(frame_error),
    .overrun(overrun),
    .parity_error(parity_error)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int fe_n = 0;
  int ov_n = 0;
  int pe_n = 0;
  logic [7:0] acc_q[$];

  always @(posedge clk) begin
    if (frame_error) fe_n++;
    if (overrun) ov_n++;
    if (parity_error) pe_n++;
    if (rx_if.data_out_valid && rx_if.data_out_ready)
      acc_q.push_back(rx_if.data_out);
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input logic b, input int n);
    serial_in = b;
    repeat (n) @(negedge clk);
  endtask

  // Stop sample lands on the 220th posedge into the stop bit
  // (2-FF sync + idle detect + half bit); rdy_stop hits that edge.
  task automatic send_frame(input logic [7:0] d,
                            input logic stop_b,
                            input logic par_b,
                            input bit rdy_stop);
    drive_bit(1'b0, BIT_T);
    for (int i = 0; i < 8; i++)
      drive_bit(d[i], BIT_T);
`ifdef UART_RX_PARITY_EN
    drive_bit(par_b, BIT_T);
`else
    if (par_b) serial_in = 1'b1;
`endif
    serial_in = stop_b;
    if (rdy_stop) begin
      repeat (219) @(negedge clk);
      rx_if.data_out_ready = 1'b1;
      @(negedge clk);
      rx_if.data_out_ready = 1'b0;
      repeat (BIT_T - 220) @(negedge clk);
    end else begin
      repeat (BIT_T) @(negedge clk);
    end
    serial_in = 1'b1;
  endtask

  task automatic consume();
    rx_if.data_out_ready = 1'b1;
    @(negedge clk);
    rx_if.data_out_ready = 1'b0;
  endtask

  initial begin
    int fe0, ov0, pe0, base, nrnd;
    logic [7:0] exp_q[$];
    logic [7:0] d;

    rx_if.data_out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", rx_if.data_out_valid, 0);
    check("rst_data", rx_if.data_out, 8'h00);
    check("rst_flags", {frame_error, overrun, parity_error}, 0);
    reset = 1'b0;
    repeat (20) @(negedge clk);

    // 1: hold then single-cycle consume
    send_frame(8'hA5, 1'b1, ^8'hA5, 0);
    check("t1_data", rx_if.data_out, 8'hA5);
    check("t1_valid", rx_if.data_out_valid, 1);
    repeat (2000) @(negedge clk);
    check("t1_hold_data", rx_if.data_out, 8'hA5);
    check("t1_hold_valid", rx_if.data_out_valid, 1);
    consume();
    check("t1_cleared", rx_if.data_out_valid, 0);
    check("t1_acc", acc_q[$], 8'hA5);

    // 2: short low glitch
    fe0 = fe_n; ov0 = ov_n; pe0 = pe_n;
    drive_bit(1'b0, 100);
    drive_bit(1'b1, 500);
    check("t2_valid", rx_if.data_out_valid, 0);
    check("t2_flags", fe_n - fe0 + ov_n - ov0 + pe_n - pe0, 0);

    // 3: bad stop then held-low break
    fe0 = fe_n; ov0 = ov_n;
    send_frame(8'h3C, 1'b0, ^8'h3C, 0);
    drive_bit(1'b0, 5 * BIT_T);
    drive_bit(1'b1, 2 * BIT_T);
    check("t3_fe_count", fe_n - fe0, 1);
    check("t3_no_valid", rx_if.data_out_valid, 0);
    check("t3_no_ov", ov_n - ov0, 0);
    send_frame(8'h5A, 1'b1, ^8'h5A, 0);
    check("t3_next", rx_if.data_out, 8'h5A);
    check("t3_next_v", rx_if.data_out_valid, 1);
    consume();

    // 4: overrun, then same-edge consume
    ov0 = ov_n;
    send_frame(8'h11, 1'b1, ^8'h11, 0);
    send_frame(8'h22, 1'b1, ^8'h22, 0);
    check("t4_ov_count", ov_n - ov0, 1);
    check("t4_kept", rx_if.data_out, 8'h11);
    check("t4_kept_v", rx_if.data_out_valid, 1);
    consume();
    ov0 = ov_n;
    send_frame(8'h11, 1'b1, ^8'h11, 0);
    send_frame(8'h22, 1'b1, ^8'h22, 1);
    check("t4_same_edge", rx_if.data_out, 8'h22);
    check("t4_same_v", rx_if.data_out_valid, 1);
    check("t4_no_ov", ov_n - ov0, 0);
    check("t4_acc11", acc_q[$], 8'h11);
    consume();

    // 5: reset mid-frame with a byte pending
    send_frame(8'h6E, 1'b1, ^8'h6E, 0);
    fe0 = fe_n; ov0 = ov_n;
    drive_bit(1'b0, BIT_T);
    for (int i = 0; i < 4; i++) drive_bit(1'b1, BIT_T);
    drive_bit(1'b1, 100);
    reset = 1'b1;
    #1;
    check("t5_rst_valid", rx_if.data_out_valid, 0);
    check("t5_rst_data", rx_if.data_out, 8'h00);
    check("t5_rst_flags", {frame_error, overrun, parity_error}, 0);
    @(negedge clk);
    reset = 1'b0;
    drive_bit(1'b1, 6 * BIT_T);
    send_frame(8'h81, 1'b1, ^8'h81, 0);
    check("t5_data", rx_if.data_out, 8'h81);
    check("t5_flags", fe_n - fe0 + ov_n - ov0, 0);
    consume();

`ifdef UART_RX_PARITY_EN
    // 6: parity good and bad
    pe0 = pe_n;
    send_frame(8'h07, 1'b1, 1'b1, 0);
    check("t6_good", rx_if.data_out, 8'h07);
    consume();
    send_frame(8'h07, 1'b1, 1'b0, 0);
    check("t6_pe_count", pe_n - pe0, 1);
    check("t6_no_valid", rx_if.data_out_valid, 0);
`else
    check("t6_pe_tied", parity_error, 0);
`endif

    // random stream with ready held high
    rx_if.data_out_ready = 1'b1;
    base = acc_q.size();
    ov0 = ov_n; fe0 = fe_n;
    nrnd = 5;
    for (int i = 0; i < nrnd; i++) begin
      d = 8'($urandom);
      exp_q.push_back(d);
      send_frame(d, 1'b1, ^d, 0);
      drive_bit(1'b1, $urandom_range(0, 300));
    end
    repeat (5) @(negedge clk);
    rx_if.data_out_ready = 1'b0;
    check("rnd_count", acc_q.size() - base, nrnd);
    for (int i = 0; i < nrnd; i++) begin
      if (base + i < acc_q.size())
        check($sformatf("rnd_byte%0d", i),
              acc_q[base + i], exp_q[i]);
    end
    check("rnd_flags", ov_n - ov0 + fe_n - fe0, 0);
    check("rnd_idle", rx_if.data_out_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
